// File: rtl/hazard_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
//
// Shared definitions for the pipeline hazard / stall controller:
//   - stall_state_e : controller FSM states (RUN, WAIT_I, WAIT_D, WAIT_BOTH)
//   - EN_*          : stage latch enable vectors, ordered {pc, id, ex, m, wb}
//   - fsel_width()  : width of a forward select able to encode N_PROD + 1
//                     choices (register file plus one per producer stage)
// ---------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_I    = 2'd1,
    WAIT_D    = 2'd2,
    WAIT_BOTH = 2'd3
  } stall_state_e;

  // Enable vectors, bit 4 = PC down to bit 0 = MEM/WB.
  localparam logic [4:0] EN_ALL      = 5'b11111;
  localparam logic [4:0] EN_STALL_FE = 5'b00111;
  localparam logic [4:0] EN_NONE     = 5'b00000;

  // Select 0 means "register file", k+1 means "producer k".
  function automatic int fsel_width(input int n_prod);
    return $clog2(n_prod + 1);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_if
//
// Bundle of every signal between the pipeline and the hazard/stall
// controller except the clock and reset.
//
// Pipeline -> controller:
//   rs_id, rt_id, use_rs, use_rt   source operands of the ID instruction
//   prod_dest, prod_wr, prod_load  per-producer destination / write / load
//   i_hit, d_req, d_hit            cache lookups this cycle
//   i_ready, d_ready               one-cycle miss-fill completion pulses
//   redirect                       ID-stage mispredict
// Controller -> pipeline:
//   pc_we, id_we, ex_we, m_we, wb_we  stage latch enables
//   bubble_ex, flush_if               NOP injection into ID/EX, IF squash
//   fwd_sel_a, fwd_sel_b              forward selects for rs / rt
//   both_access                       both caches are being waited on
//   cnt_i_stall, cnt_d_stall, cnt_lu  saturating performance counters
//
// Modports: slave = the controller, master = the pipeline side.
// ---------------------------------------------------------------------------
interface hazard_stall_ctrl_if
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int RA_W   = 2,
  parameter int N_PROD = 3,
  parameter int CNT_W  = 16,
  parameter int FSEL_W = fsel_width(N_PROD)
);

  logic [RA_W-1:0]        rs_id;
  logic [RA_W-1:0]        rt_id;
  logic                   use_rs;
  logic                   use_rt;
  logic [N_PROD*RA_W-1:0] prod_dest;
  logic [N_PROD-1:0]      prod_wr;
  logic [N_PROD-1:0]      prod_load;
  logic                   i_hit;
  logic                   d_req;
  logic                   d_hit;
  logic                   i_ready;
  logic                   d_ready;
  logic                   redirect;

  logic                   pc_we;
  logic                   id_we;
  logic                   ex_we;
  logic                   m_we;
  logic                   wb_we;
  logic                   bubble_ex;
  logic                   flush_if;
  logic [FSEL_W-1:0]      fwd_sel_a;
  logic [FSEL_W-1:0]      fwd_sel_b;
  logic                   both_access;
  logic [CNT_W-1:0]       cnt_i_stall;
  logic [CNT_W-1:0]       cnt_d_stall;
  logic [CNT_W-1:0]       cnt_lu;

  modport slave (
    input  rs_id, rt_id, use_rs, use_rt, prod_dest, prod_wr, prod_load,
           i_hit, d_req, d_hit, i_ready, d_ready, redirect,
    output pc_we, id_we, ex_we, m_we, wb_we, bubble_ex, flush_if,
           fwd_sel_a, fwd_sel_b, both_access,
           cnt_i_stall, cnt_d_stall, cnt_lu
  );

  modport master (
    output rs_id, rt_id, use_rs, use_rt, prod_dest, prod_wr, prod_load,
           i_hit, d_req, d_hit, i_ready, d_ready, redirect,
    input  pc_we, id_we, ex_we, m_we, wb_we, bubble_ex, flush_if,
           fwd_sel_a, fwd_sel_b, both_access,
           cnt_i_stall, cnt_d_stall, cnt_lu
  );

endinterface

// File: rtl/hazard_stall_ctrl_match.sv
// ---------------------------------------------------------------------------
// hazard_fwd_match
//
// Combinational priority match of one source register against N_PROD
// producer stages. The youngest producer (lowest index) holds the most
// recent value, so it wins.
//
// Ports:
//   src_i        source register address
//   use_i        the ID instruction actually reads src_i
//   prod_dest_i  packed destinations, producer k at [k*RA_W +: RA_W]
//   prod_wr_i    producer k writes the register file
//   prod_load_i  producer k is a load
//   sel_o        0 = register file, k+1 = forward from producer k
//   load_hit_o   a load among the first LU_GAP producers matches src_i
// ---------------------------------------------------------------------------
module hazard_fwd_match
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int RA_W     = 2,
  parameter int N_PROD   = 3,
  parameter int LU_GAP   = 1,
  parameter int ZERO_REG = 0,
  parameter int FSEL_W   = fsel_width(N_PROD)
) (
  input  logic [RA_W-1:0]        src_i,
  input  logic                   use_i,
  input  logic [N_PROD*RA_W-1:0] prod_dest_i,
  input  logic [N_PROD-1:0]      prod_wr_i,
  input  logic [N_PROD-1:0]      prod_load_i,
  output logic [FSEL_W-1:0]      sel_o,
  output logic                   load_hit_o
);

  logic [N_PROD-1:0] match;
  logic              zeroBlock;

  // With ZERO_REG set, register 0 is hard-wired and never forwarded.
  assign zeroBlock = (ZERO_REG != 0) && (src_i == '0);

  // Per-producer match vector.
  always_comb begin
    match = '0;
    for (int k = 0; k < N_PROD; k++) begin
      match[k] = prod_wr_i[k] & use_i & ~zeroBlock &
                 (prod_dest_i[k*RA_W +: RA_W] == src_i);
    end
  end

  // Priority select: scanning from the oldest producer down lets the
  // youngest match overwrite older ones. Only loads close enough to ID
  // (index below LU_GAP) cannot be forwarded in time and need a bubble.
  always_comb begin
    sel_o      = '0;
    load_hit_o = 1'b0;
    for (int k = N_PROD - 1; k >= 0; k--) begin
      if (match[k]) begin
        sel_o = FSEL_W'(k + 1);
      end
    end
    for (int k = 0; k < N_PROD; k++) begin
      load_hit_o = load_hit_o | (prod_load_i[k] & match[k] & (k < LU_GAP));
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Pipeline hazard / stall controller for the cached 5-stage CPU.
//   - operand forwarding selects for N_PROD producer stages
//   - load-use bubble detection
//   - I- and D-cache miss stalls whose fills may complete in different cycles
//   - redirect flush gating (only when PC and ID are both advancing)
//   - saturating stall performance counters
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    hazard_stall_ctrl_if.slave, see the interface for signal list
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int RA_W     = 2,
  parameter int N_PROD   = 3,
  parameter int LU_GAP   = 1,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 16,
  parameter int FSEL_W   = fsel_width(N_PROD)
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  bus
);

  stall_state_e     state_q, state_d;
  logic             i_done_q, i_done_d;
  logic             d_done_q, d_done_d;
  logic [CNT_W-1:0] cnt_i_stall_q;
  logic [CNT_W-1:0] cnt_d_stall_q;
  logic [CNT_W-1:0] cnt_lu_q;

  logic [4:0] enables;
  logic       bubble;
  logic       luBubble;
  logic       releaseCycle;
  logic       missI;
  logic       missD;
  logic       luHaz;
  logic       rsLoadHit;
  logic       rtLoadHit;
  logic       iStallInc;
  logic       dStallInc;

  // Forwarding / load-use matching for both source operands.
  hazard_fwd_match #(
    .RA_W     (RA_W),
    .N_PROD   (N_PROD),
    .LU_GAP   (LU_GAP),
    .ZERO_REG (ZERO_REG),
    .FSEL_W   (FSEL_W)
  ) u_match_rs (
    .src_i       (bus.rs_id),
    .use_i       (bus.use_rs),
    .prod_dest_i (bus.prod_dest),
    .prod_wr_i   (bus.prod_wr),
    .prod_load_i (bus.prod_load),
    .sel_o       (bus.fwd_sel_a),
    .load_hit_o  (rsLoadHit)
  );

  hazard_fwd_match #(
    .RA_W     (RA_W),
    .N_PROD   (N_PROD),
    .LU_GAP   (LU_GAP),
    .ZERO_REG (ZERO_REG),
    .FSEL_W   (FSEL_W)
  ) u_match_rt (
    .src_i       (bus.rt_id),
    .use_i       (bus.use_rt),
    .prod_dest_i (bus.prod_dest),
    .prod_wr_i   (bus.prod_wr),
    .prod_load_i (bus.prod_load),
    .sel_o       (bus.fwd_sel_b),
    .load_hit_o  (rtLoadHit)
  );

  assign luHaz = rsLoadHit | rtLoadHit;
  assign missI = ~bus.i_hit;
  assign missD = bus.d_req & ~bus.d_hit;

  // Next-state and stage-enable logic. A D-miss freezes the whole pipe,
  // an I-miss or load-use only holds PC/IF/ID and feeds a NOP into EX.
  // On the cycle a miss is released the pipe advances, but a pending
  // load-use is still honoured; new misses are only looked at from RUN.
  always_comb begin
    state_d      = state_q;
    i_done_d     = i_done_q;
    d_done_d     = d_done_q;
    enables      = EN_ALL;
    bubble       = 1'b0;
    luBubble     = 1'b0;
    releaseCycle = 1'b0;

    case (state_q)
      RUN: begin
        if (missD && missI) begin
          state_d = WAIT_BOTH;
        end else if (missD) begin
          state_d = WAIT_D;
        end else if (missI) begin
          state_d = WAIT_I;
        end

        if (missD) begin
          enables = EN_NONE;
        end else if (missI) begin
          enables = EN_STALL_FE;
          bubble  = 1'b1;
        end else if (luHaz) begin
          enables  = EN_STALL_FE;
          bubble   = 1'b1;
          luBubble = 1'b1;
        end
      end

      WAIT_I: begin
        if (missD) begin
          // The fill may finish in the very cycle we escalate; remember it.
          state_d = WAIT_BOTH;
          enables = EN_NONE;
          if (bus.i_ready) begin
            i_done_d = 1'b1;
          end
        end else if (bus.i_ready) begin
          state_d      = RUN;
          releaseCycle = 1'b1;
        end else begin
          enables = EN_STALL_FE;
          bubble  = 1'b1;
        end
      end

      WAIT_D: begin
        if (bus.d_ready) begin
          state_d      = RUN;
          releaseCycle = 1'b1;
        end else begin
          enables = EN_NONE;
        end
      end

      WAIT_BOTH: begin
        if (bus.i_ready) begin
          i_done_d = 1'b1;
        end
        if (bus.d_ready) begin
          d_done_d = 1'b1;
        end
        if ((i_done_q || bus.i_ready) && (d_done_q || bus.d_ready)) begin
          state_d      = RUN;
          i_done_d     = 1'b0;
          d_done_d     = 1'b0;
          releaseCycle = 1'b1;
        end else begin
          enables = EN_NONE;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    if (releaseCycle && luHaz) begin
      enables  = EN_STALL_FE;
      bubble   = 1'b1;
      luBubble = 1'b1;
    end

    // While in reset the pipeline free-runs so its own reset can propagate.
    if (reset) begin
      enables  = EN_ALL;
      bubble   = 1'b0;
      luBubble = 1'b0;
    end
  end

  // Stall cycles are charged to a cache until its fill has been seen.
  assign iStallInc = (state_q == WAIT_I) || ((state_q == WAIT_BOTH) && !i_done_q);
  assign dStallInc = (state_q == WAIT_D) || ((state_q == WAIT_BOTH) && !d_done_q);

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt,
                                              input logic             inc);
    return (inc && (cnt != '1)) ? cnt + 1'b1 : cnt;
  endfunction

  // State, sticky fill flags and performance counters. Reset always lands
  // in RUN; any in-flight fill is left to the cache to sort out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      i_done_q      <= 1'b0;
      d_done_q      <= 1'b0;
      cnt_i_stall_q <= '0;
      cnt_d_stall_q <= '0;
      cnt_lu_q      <= '0;
    end else begin
      state_q       <= state_d;
      i_done_q      <= i_done_d;
      d_done_q      <= d_done_d;
      cnt_i_stall_q <= satInc(cnt_i_stall_q, iStallInc);
      cnt_d_stall_q <= satInc(cnt_d_stall_q, dStallInc);
      cnt_lu_q      <= satInc(cnt_lu_q, luBubble);
    end
  end

  // A redirect only squashes IF when ID is advancing; a stalled redirect
  // is presented again by ID on the release cycle.
  assign bus.pc_we       = enables[4];
  assign bus.id_we       = enables[3];
  assign bus.ex_we       = enables[2];
  assign bus.m_we        = enables[1];
  assign bus.wb_we       = enables[0];
  assign bus.bubble_ex   = bubble;
  assign bus.flush_if    = bus.redirect & enables[4] & enables[3] & ~reset;
  assign bus.both_access = (state_q == WAIT_BOTH) & ~reset;
  assign bus.cnt_i_stall = cnt_i_stall_q;
  assign bus.cnt_d_stall = cnt_d_stall_q;
  assign bus.cnt_lu      = cnt_lu_q;

endmodule
